// File: rtl/imm_gen_pipe_if.sv
// Handshake and payload bundle between decode, the immediate generator and execute.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc_imm;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc_imm
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_pc_imm
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: decodes format, sign-extends the immediate, precomputes
// pc+imm and holds results in a 2-entry skid buffer; counts illegal opcodes for debug.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  imm_gen_pipe_if.slave    bus,
  output logic [CNT_W-1:0] illegal_count
);
  localparam bit          RV64  = (XLEN == 64);
  localparam int unsigned FMT_W = 3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_R_W    = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_W  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [FMT_W-1:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  logic [31:0]      w_instr;
  fmt_e             w_fmt;
  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_imm;
  entry_t           w_new;
  logic             w_in_ready;
  logic             w_push;
  logic             w_pop;

  entry_t           r_head, r_tail, w_head_n, w_tail_n;
  logic             r_vld0, r_vld1, w_vld0_n, w_vld1_n;
  logic [CNT_W-1:0] r_ill_cnt, w_ill_cnt_n;

  assign w_instr = bus.in_instr;

  // Format decode; the 32-bit immediate is already sign-extended from instr[31].
  always_comb begin
    w_fmt   = FMT_ILL;
    w_imm32 = '0;
    if (w_instr[1:0] == 2'b11) begin
      case (w_instr[6:0])
        OP_R:                                        w_fmt = FMT_R;
        OP_R_W:                                      if (RV64) w_fmt = FMT_R;
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: w_fmt = FMT_I;
        OP_IMM_W:                                    if (RV64) w_fmt = FMT_I;
        OP_STORE:                                    w_fmt = FMT_S;
        OP_BRANCH:                                   w_fmt = FMT_B;
        OP_LUI, OP_AUIPC:                            w_fmt = FMT_U;
        OP_JAL:                                      w_fmt = FMT_J;
        default:                                     w_fmt = FMT_ILL;
      endcase
    end
    case (w_fmt)
      FMT_I:   w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
      FMT_S:   w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      FMT_B:   w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                          w_instr[11:8], 1'b0};
      FMT_U:   w_imm32 = {w_instr[31:12], 12'h000};
      FMT_J:   w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                          w_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign w_imm          = XLEN'($signed(w_imm32));
  assign w_new.imm      = w_imm;
  assign w_new.pc_imm   = bus.in_pc + w_imm;
  assign w_new.fmt      = w_fmt;
  assign w_new.illegal  = (w_fmt == FMT_ILL);

  assign w_in_ready = !r_vld1 && !flush && !reset;
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_pop      = r_vld0 && bus.out_ready;

  // Shift-style buffer: head feeds the outputs directly, empty slots are held at zero.
  always_comb begin
    w_head_n    = r_head;
    w_tail_n    = r_tail;
    w_vld0_n    = r_vld0;
    w_vld1_n    = r_vld1;
    w_ill_cnt_n = r_ill_cnt;
    if (flush) begin
      w_head_n = '0;
      w_tail_n = '0;
      w_vld0_n = 1'b0;
      w_vld1_n = 1'b0;
    end else begin
      case ({w_push, w_pop})
        // A push implies the tail is empty, so push+pop just replaces the head.
        2'b11: w_head_n = w_new;
        2'b10: begin
          if (r_vld0) begin
            w_tail_n = w_new;
            w_vld1_n = 1'b1;
          end else begin
            w_head_n = w_new;
            w_vld0_n = 1'b1;
          end
        end
        2'b01: begin
          w_head_n = r_tail;
          w_tail_n = '0;
          w_vld0_n = r_vld1;
          w_vld1_n = 1'b0;
        end
        default: ;
      endcase
    end
    if (w_push && w_new.illegal && (r_ill_cnt != {CNT_W{1'b1}})) begin
      w_ill_cnt_n = r_ill_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_vld0    <= 1'b0;
      r_vld1    <= 1'b0;
      r_ill_cnt <= '0;
    end else begin
      r_head    <= w_head_n;
      r_tail    <= w_tail_n;
      r_vld0    <= w_vld0_n;
      r_vld1    <= w_vld1_n;
      r_ill_cnt <= w_ill_cnt_n;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_vld0;
  assign bus.out_imm     = r_head.imm;
  assign bus.out_pc_imm  = r_head.pc_imm;
  assign bus.out_fmt     = r_head.fmt;
  assign bus.out_illegal = r_head.illegal;
  assign illegal_count   = r_ill_cnt;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: an RV32 (CNT_W=16) and an RV64 (CNT_W=2) instance share one stimulus stream.
module tb_imm_gen_pipe;
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [2:0]  fmt32;
  } vec_t;

  typedef struct packed {
    logic [63:0] imm;
    logic [63:0] pcimm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] pc64 = '0;
  logic [15:0] cnt32;
  logic [1:0]  cnt64;

  int   checks = 0;
  int   errors = 0;
  bit   model_ok = 1'b0;
  int   m32 = 0;
  int   m64 = 0;
  exp_t q32[$];
  exp_t q64[$];
  exp_t cur32 = '0;
  exp_t cur64 = '0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) b32();
  imm_gen_pipe_if #(.XLEN(64)) b64();

  assign b32.in_valid  = in_valid;
  assign b32.in_instr  = in_instr;
  assign b32.in_pc     = pc64[31:0];
  assign b32.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.in_instr  = in_instr;
  assign b64.in_pc     = pc64;
  assign b64.out_ready = out_ready;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .bus(b32), .illegal_count(cnt32)
  );
  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .bus(b64), .illegal_count(cnt64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [31:0] instr, input logic [63:0] pc,
                         input logic [63:0] imm64, input logic [2:0] f64, input logic [2:0] f32);
    vec_t v;
    v.instr = instr; v.pc = pc; v.imm64 = imm64; v.fmt64 = f64; v.fmt32 = f32;
    vecs.push_back(v);
  endtask

  function automatic exp_t mk32(input vec_t v);
    exp_t e;
    logic [31:0] im;
    im      = (v.fmt32 == 3'd7) ? 32'h0 : v.imm64[31:0];
    e.imm   = {32'h0, im};
    e.pcimm = {32'h0, v.pc[31:0] + im};
    e.fmt   = v.fmt32;
    e.ill   = (v.fmt32 == 3'd7);
    return e;
  endfunction

  function automatic exp_t mk64(input vec_t v);
    exp_t e;
    e.imm   = v.imm64;
    e.pcimm = v.pc + v.imm64;
    e.fmt   = v.fmt64;
    e.ill   = (v.fmt64 == 3'd7);
    return e;
  endfunction

  task automatic check_dut(input string t, input logic vld, input logic rdy,
                           input logic [63:0] imm, input logic [63:0] pcimm,
                           input logic [2:0] fmt, input logic ill, input logic [63:0] cnt,
                           input exp_t h, input bit hv, input bit erdy, input int ecnt);
    chk({t, ".in_ready"},  64'(rdy),   64'(erdy));
    chk({t, ".out_valid"}, 64'(vld),   64'(hv));
    chk({t, ".out_imm"},   imm,        h.imm);
    chk({t, ".out_pc_imm"}, pcimm,     h.pcimm);
    chk({t, ".out_fmt"},   64'(fmt),   64'(h.fmt));
    chk({t, ".out_illegal"}, 64'(ill), 64'(h.ill));
    chk({t, ".illegal_count"}, cnt,    64'(ecnt));
  endtask

  // Monitor: compare DUT against the scoreboard state, then apply this cycle's events.
  always @(negedge clk) begin : monitor
    bit   erdy;
    bit   hv;
    bit   acc;
    exp_t h32;
    exp_t h64;
    if (model_ok) begin
      erdy = (q32.size() < 2) && !flush && !reset;
      hv   = (q32.size() > 0);
      h32  = hv ? q32[0] : '0;
      h64  = hv ? q64[0] : '0;
      check_dut("rv32", b32.out_valid, b32.in_ready, 64'(b32.out_imm), 64'(b32.out_pc_imm),
                b32.out_fmt, b32.out_illegal, 64'(cnt32), h32, hv, erdy, m32);
      check_dut("rv64", b64.out_valid, b64.in_ready, b64.out_imm, b64.out_pc_imm,
                b64.out_fmt, b64.out_illegal, 64'(cnt64), h64, hv, erdy, m64);
    end
    if (reset) begin
      q32.delete(); q64.delete();
      m32 = 0; m64 = 0;
      model_ok = 1'b1;
    end else if (flush) begin
      q32.delete(); q64.delete();
    end else begin
      acc = in_valid && (q32.size() < 2);
      if ((q32.size() > 0) && out_ready) begin
        void'(q32.pop_front());
        void'(q64.pop_front());
      end
      if (acc) begin
        q32.push_back(cur32);
        q64.push_back(cur64);
        if (cur32.ill && (m32 < 65535)) m32++;
        if (cur64.ill && (m64 < 3)) m64++;
      end
    end
  end

  task automatic drive(input vec_t v);
    in_instr = v.instr;
    pc64     = v.pc;
    cur32    = mk32(v);
    cur64    = mk64(v);
  endtask

  task automatic send(input vec_t v);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    drive(v);
    while (!acc && (guard < 50)) begin
      @(negedge clk);
      acc = b32.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout instr %h not accepted within %0d cycles", v.instr, guard);
    end
  endtask

  initial begin
    add_vec(32'hFFF00093, 64'h100, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1);
    add_vec(32'h8000B093, 64'h200, 64'hFFFFFFFFFFFFF800, 3'd1, 3'd1);
    add_vec(32'h123452B7, 64'h0,   64'h0000000012345000, 3'd4, 3'd4);
    add_vec(32'h800002B7, 64'h0,   64'hFFFFFFFF80000000, 3'd4, 3'd4);
    add_vec(32'hFFDFF06F, 64'h100, 64'hFFFFFFFFFFFFFFFC, 3'd5, 3'd5);
    add_vec(32'h0000007F, 64'h40,  64'h0,                3'd7, 3'd7);
    add_vec(32'h003100B3, 64'h44,  64'h0,                3'd0, 3'd0);
    add_vec(32'hFE512C23, 64'h48,  64'hFFFFFFFFFFFFFFF8, 3'd2, 3'd2);
    add_vec(32'hFE209CE3, 64'h50,  64'hFFFFFFFFFFFFFFF8, 3'd3, 3'd3);
    add_vec(32'h000000E3, 64'h54,  64'h800,              3'd3, 3'd3);
    add_vec(32'h001000EF, 64'h58,  64'h800,              3'd5, 3'd5);
    add_vec(32'hFFF14083, 64'h5C,  64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1);
    add_vec(32'hFFF0809B, 64'h60,  64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd7);
    add_vec(32'h003100BB, 64'h64,  64'h0,                3'd0, 3'd7);
    add_vec(32'hFFF00090, 64'h68,  64'h0,                3'd7, 3'd7);
    add_vec(32'h00001017, 64'h1000, 64'h1000,            3'd4, 3'd4);
    add_vec(32'h02000093, 64'hFFFFFFFFFFFFFFF0, 64'h20,  3'd1, 3'd1);
    add_vec(32'hFFC08067, 64'h70,  64'hFFFFFFFFFFFFFFFC, 3'd1, 3'd1);
    add_vec(32'h00000073, 64'h74,  64'h0,                3'd1, 3'd1);
    add_vec(32'h0000000F, 64'h78,  64'h0,                3'd1, 3'd1);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;

    foreach (vecs[i]) send(vecs[i]);
    repeat (3) @(posedge clk);
    #1;

    // A, B fill the buffer, C stalls until the consumer opens up
    out_ready = 1'b0;
    fork
      begin
        send(vecs[0]);
        send(vecs[4]);
        send(vecs[5]);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    repeat (5) send(vecs[5]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_rv64.illegal_count", 64'(cnt64), 64'd3);
    @(posedge clk);
    #1;

    // Flush with two entries buffered while a new offer and a pop are also presented
    out_ready = 1'b0;
    send(vecs[2]);
    send(vecs[3]);
    in_valid = 1'b1;
    drive(vecs[6]);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_rv32.out_valid", 64'(b32.out_valid), 64'd0);
    chk("flush_rv64.illegal_count", 64'(cnt64), 64'd3);
    @(posedge clk);
    #1;

    // Reset mid-stream with a full buffer
    out_ready = 1'b0;
    send(vecs[7]);
    send(vecs[8]);
    in_valid = 1'b1;
    drive(vecs[9]);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rv64.in_ready", 64'(b64.in_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_rv64.illegal_count", 64'(cnt64), 64'd0);
    chk("rst_rv64.out_valid", 64'(b64.out_valid), 64'd0);
    chk("rst_rv32.out_imm", 64'(b32.out_imm), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(vecs[9]);
    send(vecs[12]);
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
